// File: rtl/gshare_pkg.sv
// Widths and the branch record shared by the gshare predictor and its training queue.
package gshare_pkg;

    localparam int PC_W   = 7;
    localparam int HIST_W = 7;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] history;
        logic              taken;
    } branch_entry_t;

endpackage

// File: rtl/branch_train_queue.sv
// In-order queue of in-flight predictions; pops the oldest on resolution and drives
// the predictor's training port, squashing wrong-path entries on a misprediction.
module branch_train_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = gshare_pkg::PC_W,
    parameter int HIST_W = gshare_pkg::HIST_W
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       predict_valid,
    input  logic [PC_W-1:0]            predict_pc,
    input  logic                       predict_taken,
    input  logic [HIST_W-1:0]          predict_history,
    output logic                       alloc_ready,
    output logic                       overflow,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       resolve_err,
    output logic                       train_valid,
    output logic                       train_taken,
    output logic                       train_mispredicted,
    output logic [PC_W-1:0]            train_pc,
    output logic [HIST_W-1:0]          train_history,
    output logic [$clog2(DEPTH):0]     count
);

    import gshare_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a prediction is accepted on the edge where predict_valid && alloc_ready.
    // There is no backpressure to the predictor; a prediction offered while full is
    // dropped and flagged by overflow. resolve_valid has no ready: it always targets the
    // oldest entry and is flagged by resolve_err when nothing is in flight.

    branch_entry_t entries [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic             full;
    logic             pop;
    logic             mispred;
    logic             alloc;
    logic             drop;
    logic             empty_resolve;
    branch_entry_t    head_entry;
    logic [PTR_W-1:0] head_next, tail_next;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        full          = (count_q == CNT_W'(DEPTH));
        head_entry    = entries[head_q];
        pop           = resolve_valid && (count_q != '0);
        empty_resolve = resolve_valid && (count_q == '0);
        mispred       = pop && (resolve_taken ^ head_entry.taken);
        // A prediction made alongside a misprediction is on the wrong path: neither
        // stored nor reported as an overflow.
        alloc         = predict_valid && !full && !mispred;
        drop          = predict_valid && full && !mispred;

        head_next  = head_q;
        tail_next  = tail_q;
        count_next = count_q;

        if (pop) begin
            head_next = head_q + PTR_W'(1);
        end
        if (alloc) begin
            tail_next = tail_q + PTR_W'(1);
        end

        if (mispred) begin
            tail_next  = head_q + PTR_W'(1);
            count_next = '0;
        end else begin
            count_next = count_q + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            overflow           <= 1'b0;
            resolve_err        <= 1'b0;
            train_valid        <= 1'b0;
            train_taken        <= 1'b0;
            train_mispredicted <= 1'b0;
            train_pc           <= '0;
            train_history      <= '0;
        end else begin
            head_q      <= head_next;
            tail_q      <= tail_next;
            count_q     <= count_next;
            overflow    <= drop;
            resolve_err <= empty_resolve;
            train_valid <= pop;
            if (pop) begin
                train_taken        <= resolve_taken;
                train_mispredicted <= mispred;
                train_pc           <= head_entry.pc;
                train_history      <= head_entry.history;
            end
        end
    end

    // Entry payload is only ever read behind a valid count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            entries[tail_q] <= '{pc: predict_pc, history: predict_history, taken: predict_taken};
        end
    end

    assign alloc_ready = !full;
    assign count       = count_q;

endmodule

// File: tb/tb_branch_train_queue.sv
// Bench for branch_train_queue: directed vector table, fill/drain and reset sequences,
// and a long random run checked against a reference queue model every cycle.
module tb_branch_train_queue;

    localparam int DEPTH  = 8;
    localparam int PC_W   = 7;
    localparam int HIST_W = 7;
    localparam int CNT_W  = 4;
    localparam int TW     = 2 + PC_W + HIST_W;

    logic              clk = 1'b0;
    logic              areset;
    logic              predict_valid;
    logic [PC_W-1:0]   predict_pc;
    logic              predict_taken;
    logic [HIST_W-1:0] predict_history;
    logic              alloc_ready;
    logic              overflow;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              resolve_err;
    logic              train_valid;
    logic              train_taken;
    logic              train_mispredicted;
    logic [PC_W-1:0]   train_pc;
    logic [HIST_W-1:0] train_history;
    logic [CNT_W-1:0]  count;

    branch_train_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W)) dut (
        .clk(clk), .areset(areset),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .predict_taken(predict_taken), .predict_history(predict_history),
        .alloc_ready(alloc_ready), .overflow(overflow),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_err(resolve_err), .train_valid(train_valid),
        .train_taken(train_taken), .train_mispredicted(train_mispredicted),
        .train_pc(train_pc), .train_history(train_history), .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: in-flight entries, expected training records {taken, mis, pc, hist}
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic              taken;
    } ent_t;

    ent_t            model_q[$];
    logic [TW-1:0]   exp_q[$];
    logic [TW-1:0]   last_t;
    logic            exp_tv, exp_ovf, exp_err;
    int              exp_count;
    int              tests = 0;
    int              failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic pv, input logic [PC_W-1:0] pc,
                                input logic [HIST_W-1:0] hist, input logic pt,
                                input logic rv, input logic rt, input logic rst);
        logic full, mis;
        ent_t e;
        exp_tv = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            last_t    = '0;
            exp_count = 0;
            return;
        end
        full = (model_q.size() == DEPTH);
        mis  = 1'b0;
        if (rv) begin
            if (model_q.size() > 0) begin
                e   = model_q.pop_front();
                mis = rt ^ e.taken;
                exp_q.push_back({rt, mis, e.pc, e.hist});
                exp_tv = 1'b1;
                if (mis) model_q.delete();
            end else begin
                exp_err = 1'b1;
            end
        end
        if (pv && !mis) begin
            if (full) exp_ovf = 1'b1;
            else      model_q.push_back('{pc: pc, hist: hist, taken: pt});
        end
        exp_count = model_q.size();
    endtask

    task automatic compare_outputs();
        logic [TW-1:0] t;
        check("train_valid", 32'(train_valid), 32'(exp_tv));
        if (train_valid) begin
            if (exp_q.size() == 0) begin
                check("train_unexpected", 32'(train_valid), 32'd0);
            end else begin
                last_t = exp_q.pop_front();
            end
        end else if (exp_tv && exp_q.size() > 0) begin
            t = exp_q.pop_front();
            last_t = t;
        end
        check("train_taken",   32'(train_taken),        32'(last_t[TW-1]));
        check("train_mispred", 32'(train_mispredicted), 32'(last_t[TW-2]));
        check("train_pc",      32'(train_pc),           32'(last_t[PC_W+HIST_W-1:HIST_W]));
        check("train_history", 32'(train_history),      32'(last_t[HIST_W-1:0]));
        check("count",         32'(count),              32'(exp_count));
        check("overflow",      32'(overflow),           32'(exp_ovf));
        check("resolve_err",   32'(resolve_err),        32'(exp_err));
        check("alloc_ready",   32'(alloc_ready),        32'(exp_count != DEPTH));
    endtask

    // driver: apply one cycle of inputs, advance the model, check #1 after the edge
    task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hist,
                        input logic pt, input logic rv, input logic rt, input logic rst);
        predict_valid   = pv;
        predict_pc      = pc;
        predict_history = hist;
        predict_taken   = pt;
        resolve_valid   = rv;
        resolve_taken   = rt;
        areset          = rst;
        @(posedge clk);
        model_update(pv, pc, hist, pt, rv, rt, rst);
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic              pv;
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic              pt;
        logic              rv;
        logic              rt;
        logic              x_tv;
        logic              x_mis;
        logic [PC_W-1:0]   x_pc;
        int                x_count;
        logic              x_err;
    } vec_t;

    vec_t vecs[19];

    initial begin
        predict_valid = 1'b0; predict_pc = '0; predict_taken = 1'b0; predict_history = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; areset = 1'b1;

        // pv pc hist pt rv rt | tv mis pc count err
        vecs[0]  = '{1, 7'h15, 7'h2A, 1, 0, 0,  0, 0, 7'h00, 1, 0};
        vecs[1]  = '{0, 7'h00, 7'h00, 0, 1, 1,  1, 0, 7'h15, 0, 0};
        vecs[2]  = '{1, 7'h01, 7'h11, 0, 0, 0,  0, 0, 7'h15, 1, 0};
        vecs[3]  = '{1, 7'h02, 7'h12, 0, 0, 0,  0, 0, 7'h15, 2, 0};
        vecs[4]  = '{1, 7'h03, 7'h13, 0, 0, 0,  0, 0, 7'h15, 3, 0};
        vecs[5]  = '{0, 7'h00, 7'h00, 0, 1, 1,  1, 1, 7'h01, 0, 0};
        vecs[6]  = '{0, 7'h00, 7'h00, 0, 1, 0,  0, 1, 7'h01, 0, 1};
        vecs[7]  = '{1, 7'h10, 7'h05, 1, 0, 0,  0, 1, 7'h01, 1, 0};
        vecs[8]  = '{1, 7'h11, 7'h06, 1, 0, 0,  0, 1, 7'h01, 2, 0};
        vecs[9]  = '{1, 7'h12, 7'h07, 1, 0, 0,  0, 1, 7'h01, 3, 0};
        vecs[10] = '{1, 7'h40, 7'h08, 1, 1, 1,  1, 0, 7'h10, 3, 0};
        vecs[11] = '{0, 7'h00, 7'h00, 0, 1, 1,  1, 0, 7'h11, 2, 0};
        vecs[12] = '{0, 7'h00, 7'h00, 0, 1, 1,  1, 0, 7'h12, 1, 0};
        vecs[13] = '{0, 7'h00, 7'h00, 0, 1, 1,  1, 0, 7'h40, 0, 0};
        vecs[14] = '{1, 7'h20, 7'h01, 1, 0, 0,  0, 0, 7'h40, 1, 0};
        vecs[15] = '{1, 7'h21, 7'h02, 1, 0, 0,  0, 0, 7'h40, 2, 0};
        vecs[16] = '{1, 7'h22, 7'h03, 1, 0, 0,  0, 0, 7'h40, 3, 0};
        vecs[17] = '{1, 7'h41, 7'h04, 1, 1, 0,  1, 1, 7'h20, 0, 0};
        vecs[18] = '{0, 7'h00, 7'h00, 0, 1, 0,  0, 1, 7'h20, 0, 1};

        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_train_valid", 32'(train_valid), 32'd0);
        check("reset_alloc_ready", 32'(alloc_ready), 32'd1);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].pv, vecs[i].pc, vecs[i].hist, vecs[i].pt, vecs[i].rv, vecs[i].rt, 1'b0);
            check($sformatf("vec%0d_tv", i),    32'(train_valid),        32'(vecs[i].x_tv));
            check($sformatf("vec%0d_mis", i),   32'(train_mispredicted), 32'(vecs[i].x_mis));
            check($sformatf("vec%0d_pc", i),    32'(train_pc),           32'(vecs[i].x_pc));
            check($sformatf("vec%0d_count", i), 32'(count),              32'(vecs[i].x_count));
            check($sformatf("vec%0d_err", i),   32'(resolve_err),        32'(vecs[i].x_err));
        end
        check("vec1_hist", 32'(train_history), 32'h01);

        // fill to full (pointers are mid-buffer, so this wraps), overflow, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 7'(8'h50 + i), 7'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_ready", 32'(alloc_ready), 32'd0);
        step(1'b1, 7'h7F, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_count", 32'(count), 32'd8);
        // overflow still pulses when a correct pop shares the cycle
        step(1'b1, 7'h7E, 7'h7E, 1'b1, 1'b1, 1'b0, 1'b0);
        check("full_pop_overflow", 32'(overflow), 32'd1);
        check("full_pop_pc", 32'(train_pc), 32'h50);
        check("full_pop_count", 32'(count), 32'd7);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("drain%0d_pc", i), 32'(train_pc), 32'(8'h50 + i));
        end
        check("drain_count", 32'(count), 32'd0);

        // reset mid-operation with a resolve in the same cycle
        for (int i = 0; i < 5; i++) step(1'b1, 7'(8'h60 + i), 7'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_tv", 32'(train_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("rst_quiet_tv", 32'(train_valid), 32'd0);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_empty_err", 32'(resolve_err), 32'd1);

        // random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            logic pv, rv, rt, rst;
            pv  = ($urandom_range(0, 99) < 60);
            rv  = ($urandom_range(0, 99) < 45);
            rst = ($urandom_range(0, 1999) == 0);
            if (model_q.size() > 0 && $urandom_range(0, 99) < 90) rt = model_q[0].taken;
            else rt = 1'($urandom_range(0, 1));
            step(pv, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), rv, rt, rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
